// File: rtl/array131_wrctrl_if.sv
// rtl/array131_wrctrl_if.sv - write-port bundle between requesters, clear control and the array
//
// Signals:
//   req0..2 / wa0..2 / di0..2 : write request, address and data from each requester
//   ack0..2                   : one-cycle acceptance pulse back to each requester
//   init_req / init_busy      : clear-sweep start pulse and sweep-in-progress flag
//   we / wa / di              : write port of the controlled array
// Modports:
//   master : requester/initiator side (drives requests, sees acks and the array port)
//   slave  : the write controller
interface array131_wrctrl_if #(
    parameter int ADDRBIT = 9,
    parameter int WIDTH   = 32
);
    logic               req0;
    logic               req1;
    logic               req2;
    logic [ADDRBIT-1:0] wa0;
    logic [ADDRBIT-1:0] wa1;
    logic [ADDRBIT-1:0] wa2;
    logic [WIDTH-1:0]   di0;
    logic [WIDTH-1:0]   di1;
    logic [WIDTH-1:0]   di2;
    logic               ack0;
    logic               ack1;
    logic               ack2;
    logic               init_req;
    logic               init_busy;
    logic               we;
    logic [ADDRBIT-1:0] wa;
    logic [WIDTH-1:0]   di;

    modport master (
        output req0, req1, req2,
        output wa0, wa1, wa2,
        output di0, di1, di2,
        output init_req,
        input  ack0, ack1, ack2,
        input  init_busy,
        input  we, wa, di
    );

    modport slave (
        input  req0, req1, req2,
        input  wa0, wa1, wa2,
        input  di0, di1, di2,
        input  init_req,
        output ack0, ack1, ack2,
        output init_busy,
        output we, wa, di
    );
endinterface

// File: rtl/array131_wrctrl.sv
// rtl/array131_wrctrl.sv - three-requester round-robin write controller with array clear sweep
//
// Ports:
//   wclk : array write clock
//   rst_ : asynchronous active-low reset
//   bus  : array131_wrctrl_if.slave (requests/acks, init_req/init_busy, array we/wa/di)
// All outputs come straight from flops: a grant sampled on one edge appears on
// we/wa/di/ackN for the following cycle.
module array131_wrctrl #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32
) (
    input  logic              wclk,
    input  logic              rst_,
    array131_wrctrl_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [ADDRBIT-1:0] cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDRBIT-1:0] wa_q, wa_d;
    logic [WIDTH-1:0]   di_q, di_d;
    logic [2:0]         ack_q, ack_d;
    logic               busy_q, busy_d;

    logic [2:0]         req_v;
    logic [2:0]         elig;
    logic               grant_vld;
    logic [1:0]         grant_id;
    logic               arb_en;

    assign req_v = {bus.req2, bus.req1, bus.req0};

    // A requester whose ack is currently high still holds its old request;
    // masking it stops the same write from being accepted twice.
    assign elig = req_v & ~ack_q;

    // Round-robin pick: scan ptr+2, ptr+1, ptr so the lowest offset wins last.
    always_comb begin
        int cand;
        grant_vld = 1'b0;
        grant_id  = 2'd0;
        cand      = 0;
        for (int k = 2; k >= 0; k--) begin
            cand = (int'(ptr_q) + k) % 3;
            if (elig[cand]) begin
                grant_vld = 1'b1;
                grant_id  = 2'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        di_d    = di_q;
        ack_d   = 3'b000;
        busy_d  = 1'b0;
        arb_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.init_req) begin
                    // The entry edge already launches the write of address 0.
                    state_d = CLEAR;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    wa_d    = '0;
                    di_d    = '0;
                    busy_d  = 1'b1;
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLEAR: begin
                // cnt_q is the address currently on the write port.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    arb_en  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    we_d   = 1'b1;
                    wa_d   = cnt_q + 1'b1;
                    di_d   = '0;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (arb_en && grant_vld) begin
            we_d = 1'b1;
            case (grant_id)
                2'd0: begin
                    wa_d     = bus.wa0;
                    di_d     = bus.di0;
                    ack_d[0] = 1'b1;
                    ptr_d    = 2'd1;
                end
                2'd1: begin
                    wa_d     = bus.wa1;
                    di_d     = bus.di1;
                    ack_d[1] = 1'b1;
                    ptr_d    = 2'd2;
                end
                default: begin
                    wa_d     = bus.wa2;
                    di_d     = bus.di2;
                    ack_d[2] = 1'b1;
                    ptr_d    = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            di_q    <= '0;
            ack_q   <= 3'b000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            di_q    <= di_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.we        = we_q;
    assign bus.wa        = wa_q;
    assign bus.di        = di_q;
    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.ack2      = ack_q[2];
    assign bus.init_busy = busy_q;

endmodule

// File: tb/tb_array131_wrctrl.sv
// tb/tb_array131_wrctrl.sv - scoreboard bench for array131_wrctrl
module tb_array131_wrctrl;

    localparam int ADDRBIT = 9;
    localparam int DEPTH   = 8;
    localparam int WIDTH   = 32;

    logic wclk = 1'b0;
    logic rst_ = 1'b0;
    always #5 wclk = ~wclk;

    array131_wrctrl_if #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH)) bus ();

    array131_wrctrl #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .wclk (wclk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    logic               tb_req  [3];
    logic [ADDRBIT-1:0] tb_wa   [3];
    logic [WIDTH-1:0]   tb_di   [3];
    logic               tb_init;

    assign bus.req0     = tb_req[0];
    assign bus.req1     = tb_req[1];
    assign bus.req2     = tb_req[2];
    assign bus.wa0      = tb_wa[0];
    assign bus.wa1      = tb_wa[1];
    assign bus.wa2      = tb_wa[2];
    assign bus.di0      = tb_di[0];
    assign bus.di1      = tb_di[1];
    assign bus.di2      = tb_di[2];
    assign bus.init_req = tb_init;

    typedef struct packed {
        logic [1:0]         id;
        logic [ADDRBIT-1:0] wa;
        logic [WIDTH-1:0]   di;
    } wr_t;

    wr_t exp_q [$];
    wr_t plan  [3][$];

    int checks = 0;
    int errors = 0;

    logic               o_we;
    logic               o_busy;
    logic [ADDRBIT-1:0] o_wa;
    logic [WIDTH-1:0]   o_di;
    logic [2:0]         o_ack;
    wr_t                e;
    bit                 have_e;

    task automatic plan_wr(input int n, input logic [ADDRBIT-1:0] a, input logic [WIDTH-1:0] d);
        wr_t w;
        w.id = 2'(n);
        w.wa = a;
        w.di = d;
        plan[n].push_back(w);
    endtask

    // Requester n raises its next planned write; the scoreboard expects it in request order.
    task automatic present(input int n);
        wr_t w;
        w = plan[n].pop_front();
        tb_req[n] = 1'b1;
        tb_wa[n]  = w.wa;
        tb_di[n]  = w.di;
        exp_q.push_back(w);
    endtask

    // Sample the DUT on the falling edge, pop the expected write for any ack, then let
    // acked requesters move on to their next write or drop their request.
    task automatic tick();
        @(negedge wclk);
        o_we   = bus.we;
        o_wa   = bus.wa;
        o_di   = bus.di;
        o_busy = bus.init_busy;
        o_ack  = {bus.ack2, bus.ack1, bus.ack0};
        have_e = 1'b0;
        if (o_we && o_ack != 3'b000 && exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            have_e = 1'b1;
        end
        for (int n = 0; n < 3; n++) begin
            if (o_ack[n]) begin
                if (plan[n].size() > 0) present(n);
                else tb_req[n] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_    = 1'b0;
        tb_init = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tb_req[n] = 1'b0;
            tb_wa[n]  = '0;
            tb_di[n]  = '0;
            plan[n].delete();
        end
        exp_q.delete();
        repeat (2) @(negedge wclk);
    endtask

    task automatic test_reset();
        do_reset();
        tb_req[0] = 1'b1;
        tb_init   = 1'b1;
        tick();
        checks++; if (o_we !== 1'b0)   begin errors++; $display("FAIL reset_we got %0b want 0", o_we); end
        checks++; if (o_wa !== '0)     begin errors++; $display("FAIL reset_wa got %0h want 0", o_wa); end
        checks++; if (o_di !== '0)     begin errors++; $display("FAIL reset_di got %0h want 0", o_di); end
        checks++; if (o_ack !== 3'b0)  begin errors++; $display("FAIL reset_ack got %b want 000", o_ack); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    endtask

    task automatic test_single();
        do_reset();
        plan_wr(1, 9'd5, 32'hA5A5_A5A5);
        present(1);
        rst_ = 1'b1;
        tick();
        checks++; if (have_e !== 1'b1) begin errors++; $display("FAIL single_grant got no acked write want one"); end
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL single_we got %0b want 1", o_we); end
        checks++; if (o_wa !== 9'd5) begin errors++; $display("FAIL single_wa got %0h want 5", o_wa); end
        checks++; if (o_di !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_di got %0h want a5a5a5a5", o_di); end
        checks++; if (o_ack !== 3'b010) begin errors++; $display("FAIL single_ack got %b want 010", o_ack); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (o_we !== 1'b0 || o_ack !== 3'b000) begin errors++; $display("FAIL single_pulse cyc %0d got we=%0b ack=%b want we=0 ack=000", c, o_we, o_ack); end
        end
    endtask

    task automatic test_round_robin();
        int last [3];
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 3; n++)
                plan_wr(n, 9'(16 * n + k), 32'hC0DE_0000 | 32'(n << 8) | 32'(k));
        for (int n = 0; n < 3; n++) begin
            present(n);
            last[n] = -1;
        end
        rst_ = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL rr_we cyc %0d got %0b want 1", c, o_we); end
            checks++; if (o_ack !== 3'(3'b001 << (c % 3))) begin errors++; $display("FAIL rr_order cyc %0d got ack=%b want %b", c, o_ack, 3'(3'b001 << (c % 3))); end
            checks++; if (have_e !== 1'b1) begin errors++; $display("FAIL rr_sb cyc %0d got no acked write want one", c); end
            else begin
                checks++; if (o_wa !== e.wa || o_di !== e.di) begin errors++; $display("FAIL rr_data cyc %0d got %0h/%0h want %0h/%0h", c, o_wa, o_di, e.wa, e.di); end
            end
            for (int n = 0; n < 3; n++) begin
                if (o_ack[n]) begin
                    if (last[n] >= 0) begin
                        checks++; if (c - last[n] != 3) begin errors++; $display("FAIL rr_spacing req%0d got %0d want 3", n, c - last[n]); end
                    end
                    last[n] = c;
                end
            end
        end
        tick();
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL rr_drain got we=%0b want 0", o_we); end
    endtask

    task automatic test_single_requester();
        int writes = 0;
        do_reset();
        for (int k = 0; k < 3; k++) plan_wr(2, 9'(100 + k), 32'h2222_0000 + 32'(k));
        present(2);
        rst_ = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (o_we !== ((c % 2) == 0)) begin errors++; $display("FAIL alt_we cyc %0d got %0b want %0b", c, o_we, (c % 2) == 0); end
            if (o_we) begin
                writes++;
                checks++; if (!have_e || o_ack !== 3'b100 || o_wa !== e.wa || o_di !== e.di) begin errors++; $display("FAIL alt_write cyc %0d got ack=%b %0h/%0h want ack=100 %0h/%0h", c, o_ack, o_wa, o_di, e.wa, e.di); end
            end
        end
        checks++; if (writes != 3 || exp_q.size() != 0) begin errors++; $display("FAIL alt_count got %0d writes %0d pending want 3 writes 0 pending", writes, exp_q.size()); end
    endtask

    task automatic test_clear();
        do_reset();
        plan_wr(0, 9'h1F, 32'h1234_5678);
        present(0);
        tb_init = 1'b1;
        rst_    = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            tb_init = 1'b0;
            checks++; if (o_busy !== 1'b1 || o_we !== 1'b1 || o_wa !== 9'(k) || o_di !== '0 || o_ack !== 3'b000) begin
                errors++; $display("FAIL clear_sweep k %0d got busy=%0b we=%0b wa=%0h di=%0h ack=%b want 1 1 %0h 0 000", k, o_busy, o_we, o_wa, o_di, o_ack, k);
            end
        end
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clear_end_busy got %0b want 0", o_busy); end
        checks++; if (!have_e || o_we !== 1'b1 || o_ack !== 3'b001 || o_wa !== e.wa || o_di !== e.di) begin
            errors++; $display("FAIL clear_resume got we=%0b ack=%b %0h/%0h want we=1 ack=001 1f/12345678", o_we, o_ack, o_wa, o_di);
        end
        tick();
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL clear_after got we=%0b want 0", o_we); end
    endtask

    task automatic test_clear_repulse();
        int busy_cnt = 0;
        do_reset();
        tb_init = 1'b1;
        rst_    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            tb_init = (k == 3);
            if (o_busy) busy_cnt++;
            checks++; if (o_busy !== (k < DEPTH)) begin errors++; $display("FAIL repulse_busy k %0d got %0b want %0b", k, o_busy, k < DEPTH); end
        end
        checks++; if (busy_cnt != DEPTH) begin errors++; $display("FAIL repulse_len got %0d want %0d", busy_cnt, DEPTH); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        tb_init = 1'b1;
        rst_    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tb_init = 1'b0;
            checks++; if (o_wa !== 9'(k) || o_busy !== 1'b1) begin errors++; $display("FAIL abort_pre k %0d got wa=%0h busy=%0b want %0h 1", k, o_wa, o_busy, k); end
        end
        rst_ = 1'b0;
        #1;
        checks++; if (bus.we !== 1'b0 || bus.init_busy !== 1'b0) begin errors++; $display("FAIL abort_now got we=%0b busy=%0b want 0 0", bus.we, bus.init_busy); end
        repeat (2) @(negedge wclk);
        rst_ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (o_we !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL abort_quiet k %0d got we=%0b busy=%0b want 0 0", k, o_we, o_busy); end
        end
        plan_wr(1, 9'd7, 32'h0BAD_F00D);
        present(1);
        tick();
        checks++; if (!have_e || o_we !== 1'b1 || o_ack !== 3'b010 || o_wa !== 9'd7 || o_di !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL abort_req got we=%0b ack=%b %0h/%0h want 1 010 7/0badf00d", o_we, o_ack, o_wa, o_di);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_single_requester();
        test_clear();
        test_clear_repulse();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
